// File: rtl/rr_arb_clk_rstb_if.sv
// rtl/rr_arb_clk_rstb_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arb_clk_rstb_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  modport master (output req, input gnt, gnt_valid, gnt_id, preempt);
  modport slave  (input req, output gnt, gnt_valid, gnt_id, preempt);
endinterface

// File: rtl/rr_arb_clk_rstb.sv
// rtl/rr_arb_clk_rstb.sv - round-robin arbiter with bounded hold and one-cycle owner turnaround
module rr_arb_clk_rstb #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rstb,
  rr_arb_clk_rstb_if.slave bus
);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           preempt_q, preempt_d;
  logic [IDW-1:0] winner, owner_next;
  logic [N-1:0]   owner_oh, others;
  logic           any_req, owner_req, hold_expired;

  // First set request at or after p, wrapping; rotating a doubled vector avoids a modulo per bit.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [2*N-1:0] rot;
    logic           found;
    int             s;
    rr_pick = '0;
    found   = 1'b0;
    s       = 0;
    rot     = {r, r} >> p;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        s     = int'(p) + i;
        if (s >= N) s = s - N;
        rr_pick = IDW'(s);
      end
    end
  endfunction

  assign winner       = rr_pick(bus.req, ptr_q);
  assign owner_oh     = N'(1) << owner_q;
  assign others       = bus.req & ~owner_oh;
  assign any_req      = |bus.req;
  assign owner_req    = |(bus.req & owner_oh);
  assign owner_next   = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d = BUSY;
          owner_d = winner;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A voluntary release wins over expiry, so preempt only fires while the owner still asks.
        if (!owner_req) begin
          state_d = GAP;
          ptr_d   = owner_next;
        end else if (hold_expired && (|others)) begin
          state_d   = GAP;
          ptr_d     = owner_next;
          preempt_d = 1'b1;
        end else if (MAX_HOLD != 0 && !hold_expired) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant outputs decode straight from registered state, so they change only on clock or reset.
  always_comb begin
    bus.gnt       = '0;
    bus.gnt_valid = 1'b0;
    bus.gnt_id    = '0;
    if (state_q == BUSY) begin
      bus.gnt       = owner_oh;
      bus.gnt_valid = 1'b1;
      bus.gnt_id    = owner_q;
    end
  end

  assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_rr_arb_clk_rstb.sv
// tb/tb_rr_arb_clk_rstb.sv - scoreboard bench for rr_arb_clk_rstb
module tb_rr_arb_clk_rstb;
  logic clk;
  logic rstb;
  int   total;
  int   bad;
  logic [4:0] sb[$];

  rr_arb_clk_rstb_if #(.N(4), .IDW(2)) bus ();

  rr_arb_clk_rstb #(.N(4), .IDW(2), .MAX_HOLD(8)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_id(input logic [3:0] g);
    exp_id = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) exp_id = 2'(i);
  endfunction

  task automatic do_reset();
    rstb    = 1'b0;
    bus.req = '0;
    sb.delete();
    @(posedge clk);
    #1 rstb = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] rq[$];
    logic [4:0] ex[$];
    logic [4:0] e;
    rstb    = 1'b0;
    bus.req = '0;
    #3;
    total++;
    if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== 2'd0 || bus.preempt !== 1'b0) begin
      bad++;
      $display("FAIL reset_init gnt=%b v=%b id=%0d pre=%b exp all zero", bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt);
    end
    @(posedge clk);
    #1 rstb = 1'b1;
    // Owner 1 releases so ptr moves to 2, then 2 owns when reset hits.
    rq = '{4'b0010, 4'b0000, 4'b0100, 4'b0100};
    ex = '{5'b00010, 5'b00000, 5'b00100, 5'b00100};
    for (int c = 0; c < rq.size(); c++) begin
      bus.req = rq[c];
      sb.push_back(ex[c]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.gnt !== e[3:0] || bus.preempt !== e[4] || bus.gnt_valid !== (|e[3:0]) || bus.gnt_id !== exp_id(e[3:0])) begin
        bad++;
        $display("FAIL reset_pre c=%0d gnt=%b pre=%b v=%b id=%0d exp gnt=%b pre=%b", c, bus.gnt, bus.preempt, bus.gnt_valid, bus.gnt_id, e[3:0], e[4]);
      end
    end
    #2 rstb = 1'b0;
    #1;
    total++;
    if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== 2'd0 || bus.preempt !== 1'b0) begin
      bad++;
      $display("FAIL reset_async gnt=%b v=%b id=%0d pre=%b exp all zero", bus.gnt, bus.gnt_valid, bus.gnt_id, bus.preempt);
    end
    @(posedge clk);
    #1 rstb = 1'b1;
    bus.req = 4'b1010;
    sb.push_back(5'b00010);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if (bus.gnt !== e[3:0] || bus.gnt_id !== exp_id(e[3:0]) || bus.gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_ptr gnt=%b id=%0d v=%b exp gnt=%b", bus.gnt, bus.gnt_id, bus.gnt_valid, e[3:0]);
    end
  endtask

  task automatic test_single();
    logic [3:0] rq[$];
    logic [4:0] ex[$];
    logic [4:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin rq.push_back(4'b0001); ex.push_back(5'b00001); end
    for (int i = 0; i < 3; i++) begin rq.push_back(4'b0000); ex.push_back(5'b00000); end
    for (int c = 0; c < rq.size(); c++) begin
      bus.req = rq[c];
      sb.push_back(ex[c]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.gnt !== e[3:0] || bus.preempt !== e[4] || bus.gnt_valid !== (|e[3:0]) || bus.gnt_id !== exp_id(e[3:0])) begin
        bad++;
        $display("FAIL single c=%0d gnt=%b pre=%b v=%b id=%0d exp gnt=%b pre=%b", c, bus.gnt, bus.preempt, bus.gnt_valid, bus.gnt_id, e[3:0], e[4]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] rq[$];
    logic [4:0] ex[$];
    logic [4:0] e;
    logic [3:0] bit1;
    do_reset();
    for (int o = 0; o < 5; o++) begin
      bit1 = 4'b0001 << (o % 4);
      rq.push_back(4'b1111);  ex.push_back({1'b0, bit1});
      rq.push_back(4'b1111);  ex.push_back({1'b0, bit1});
      rq.push_back(~bit1);    ex.push_back(5'b00000);
    end
    for (int c = 0; c < rq.size(); c++) begin
      bus.req = rq[c];
      sb.push_back(ex[c]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.gnt !== e[3:0] || bus.preempt !== e[4] || bus.gnt_valid !== (|e[3:0]) || bus.gnt_id !== exp_id(e[3:0])) begin
        bad++;
        $display("FAIL fairness c=%0d gnt=%b pre=%b v=%b id=%0d exp gnt=%b pre=%b", c, bus.gnt, bus.preempt, bus.gnt_valid, bus.gnt_id, e[3:0], e[4]);
      end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] rq[$];
    logic [4:0] ex[$];
    logic [4:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin rq.push_back(4'b0100); ex.push_back(5'b00100); end
    for (int i = 0; i < 5; i++) begin rq.push_back(4'b0101); ex.push_back(5'b00100); end
    rq.push_back(4'b0101); ex.push_back(5'b10000);
    rq.push_back(4'b0101); ex.push_back(5'b00001);
    rq.push_back(4'b0101); ex.push_back(5'b00001);
    rq.push_back(4'b0100); ex.push_back(5'b00000);
    rq.push_back(4'b0100); ex.push_back(5'b00100);
    rq.push_back(4'b0100); ex.push_back(5'b00100);
    rq.push_back(4'b0000); ex.push_back(5'b00000);
    rq.push_back(4'b0000); ex.push_back(5'b00000);
    for (int c = 0; c < rq.size(); c++) begin
      bus.req = rq[c];
      sb.push_back(ex[c]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.gnt !== e[3:0] || bus.preempt !== e[4] || bus.gnt_valid !== (|e[3:0]) || bus.gnt_id !== exp_id(e[3:0])) begin
        bad++;
        $display("FAIL preempt c=%0d gnt=%b pre=%b v=%b id=%0d exp gnt=%b pre=%b", c, bus.gnt, bus.preempt, bus.gnt_valid, bus.gnt_id, e[3:0], e[4]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] rq[$];
    logic [4:0] ex[$];
    logic [4:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) begin rq.push_back(4'b0100); ex.push_back(5'b00100); end
    rq.push_back(4'b1100); ex.push_back(5'b10000);
    rq.push_back(4'b1100); ex.push_back(5'b01000);
    rq.push_back(4'b1000); ex.push_back(5'b01000);
    rq.push_back(4'b0000); ex.push_back(5'b00000);
    rq.push_back(4'b0000); ex.push_back(5'b00000);
    for (int c = 0; c < rq.size(); c++) begin
      bus.req = rq[c];
      sb.push_back(ex[c]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.gnt !== e[3:0] || bus.preempt !== e[4] || bus.gnt_valid !== (|e[3:0]) || bus.gnt_id !== exp_id(e[3:0])) begin
        bad++;
        $display("FAIL saturation c=%0d gnt=%b pre=%b v=%b id=%0d exp gnt=%b pre=%b", c, bus.gnt, bus.preempt, bus.gnt_valid, bus.gnt_id, e[3:0], e[4]);
      end
    end
  endtask

  task automatic test_drop_at_expiry();
    logic [3:0] rq[$];
    logic [4:0] ex[$];
    logic [4:0] e;
    do_reset();
    rq.push_back(4'b0010); ex.push_back(5'b00010);
    for (int i = 0; i < 7; i++) begin rq.push_back(4'b1010); ex.push_back(5'b00010); end
    rq.push_back(4'b1000); ex.push_back(5'b00000);
    rq.push_back(4'b1001); ex.push_back(5'b01000);
    rq.push_back(4'b1001); ex.push_back(5'b01000);
    rq.push_back(4'b0000); ex.push_back(5'b00000);
    rq.push_back(4'b0000); ex.push_back(5'b00000);
    for (int c = 0; c < rq.size(); c++) begin
      bus.req = rq[c];
      sb.push_back(ex[c]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (bus.gnt !== e[3:0] || bus.preempt !== e[4] || bus.gnt_valid !== (|e[3:0]) || bus.gnt_id !== exp_id(e[3:0])) begin
        bad++;
        $display("FAIL drop_expiry c=%0d gnt=%b pre=%b v=%b id=%0d exp gnt=%b pre=%b", c, bus.gnt, bus.preempt, bus.gnt_valid, bus.gnt_id, e[3:0], e[4]);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rstb    = 1'b0;
    bus.req = '0;
    test_reset();
    test_single();
    test_fairness();
    test_preempt();
    test_saturation();
    test_drop_at_expiry();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
